aes_encipher_core_p: RTL and testbench
======================================

AES_ENCIPHER_CORE_P -- requirements
Module: aes_encipher_core_p

Interface
REQ-001 SHALL have parameter SBOX_LANES, default 1: number of 32-bit S-box words substituted per cycle; legal values 1, 2, 4.
REQ-002 SHALL have ports: clk input 1, system clock; reset_n input 1, asynchronous active-low reset.
REQ-003 SHALL have port next input 1: start request, sampled only in IDLE.
REQ-004 SHALL have port abort input 1: cancels the operation in progress.
REQ-005 SHALL have port keylen input 2: 0=AES-128 (Nr=10), 1=AES-192 (Nr=12), 2=AES-256 (Nr=14), 3=reserved.
REQ-006 SHALL have ports:
- round output 4: current round-key index;
- round_key input 128: key for index round, valid combinationally in the same cycle.
REQ-007 SHALL have ports:
- sboxw output 32*SBOX_LANES: words to substitute, lane 0 in the MSBs;
- new_sboxw input 32*SBOX_LANES: substituted words, same-cycle combinational return.
REQ-008 SHALL have ports:
- block input 128: plaintext, sampled on next acceptance;
- new_block output 128: state register.
REQ-009 SHALL have ports ready output 1 (idle/result valid), done output 1 (one-cycle completion pulse) and err output 1 (one-cycle reserved-keylen pulse).

Function
REQ-010 SHALL implement FSM states IDLE, INIT, SBOX, MAIN.
REQ-011 IDLE with next=1, abort=0 and keylen!=3 SHALL capture keylen internally, clear ready, go to INIT, and set the round counter to 0.
REQ-012 IDLE with next=1 and keylen=3 SHALL stay in IDLE and pulse err for one cycle.
REQ-013 INIT SHALL load new_block = block XOR round_key (round=0), increment the round counter to 1, clear the word counter, and go to SBOX.
REQ-014 SBOX SHALL last 4/SBOX_LANES cycles. In cycle k, sboxw = state words k*SBOX_LANES..k*SBOX_LANES+SBOX_LANES-1 (word 0 = bits 127:96), and those words are overwritten with new_sboxw. After the last cycle the FSM goes to MAIN.
REQ-015 MAIN with round<Nr SHALL load new_block = MixColumns(ShiftRows(state)) XOR round_key, increment round, and return to SBOX.
REQ-016 MAIN with round=Nr SHALL load new_block = ShiftRows(state) XOR round_key, set ready, pulse done, and go to IDLE.
REQ-017 Latency from the next-accept edge to ready high SHALL be 2+Nr*(4/SBOX_LANES+1) cycles. Examples: 52 for Nr=10 with SBOX_LANES=1; 22 for Nr=10 with SBOX_LANES=4.
REQ-018 MixColumns SHALL be computed internally using GF(2^8) with polynomial 0x11B.
REQ-019 sboxw SHALL be 0 outside SBOX.
REQ-020 Nr SHALL come from the captured keylen; keylen changes mid-operation SHALL have no effect.
REQ-021 next while not IDLE SHALL be ignored.
REQ-022 abort in any non-IDLE state SHALL, on the next edge:
- enter IDLE;
- clear new_block to 0;
- set ready=1;
- leave done unpulsed.
REQ-023 abort and next asserted together in IDLE SHALL start nothing; abort wins.
REQ-024 new_block SHALL hold its value in IDLE until the next accepted start or abort.

Reset
REQ-025 reset_n low SHALL asynchronously force:
- state IDLE;
- new_block=0, round=0, word counter 0;
- ready=1, done=0, err=0;
- captured keylen=0.
REQ-026 Reset mid-operation SHALL discard the operation with no done pulse.

Structure
REQ-027 Package aes_pkg SHALL hold the following shared items:
- keylen codes;
- Nr constants 10/12/14;
- FSM state encoding;
- xtime/GF multiply functions;
- ShiftRows function.
REQ-028 MixColumns SHALL be a combinational sub-module aes_mixcolumns (128 in, 128 out) shared with the decipher path.
REQ-029 An illegal SBOX_LANES value SHALL cause an elaboration-time error.

Verification
REQ-030 Bench SHALL cover the AES-128 FIPS-197 C.1 vector (SBOX_LANES=1): plaintext 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f, expect 69c4e0d86a7b0430d8cdb78070b4c55a, with done at cycle 52.
REQ-031 Bench SHALL cover the AES-192 C.2 vector (SBOX_LANES=2): key 000102…1617, expect dda97ca4864cdfe06eaf70a0ec0d7191, with done at cycle 2+12*3=38.
REQ-032 Bench SHALL cover the AES-256 C.3 vector (SBOX_LANES=4): key 000102…1e1f, expect 8ea2b7ca516745bfeafc49904b496089, with done at cycle 30. keylen SHALL be toggled to 0 mid-run with no change in result.
REQ-033 Bench SHALL cover abort asserted in round 5 SBOX: required response is IDLE next cycle, new_block=0, ready=1, no done pulse; an immediate restart SHALL then give the correct C.1 result.
REQ-034 Bench SHALL cover next with keylen=3: required response is an err pulse, ready stays 1, new_block unchanged. next pulses during a run SHALL be ignored, and the run SHALL still give the correct result.
REQ-035 Bench SHALL cover reset_n low mid-run: required response is immediate IDLE, ready=1, new_block=0, no done pulse.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: key-length codes, round counts, FSM encoding and the
// byte-level GF(2^8) / ShiftRows helpers used by both cipher directions.
package aes_pkg;

  typedef enum logic [1:0] {
    KeyLen128  = 2'd0,
    KeyLen192  = 2'd1,
    KeyLen256  = 2'd2,
    KeyLenRsvd = 2'd3
  } keylen_e;

  localparam logic [3:0] Nr128 = 4'd10;
  localparam logic [3:0] Nr192 = 4'd12;
  localparam logic [3:0] Nr256 = 4'd14;

  typedef enum logic [1:0] {
    StIdle,
    StInit,
    StSbox,
    StMain
  } aes_state_e;

  // Multiply by x modulo x^8 + x^4 + x^3 + x + 1 (0x11B).
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = '0;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  function automatic logic [3:0] num_rounds(input logic [1:0] kl);
    case (kl)
      KeyLen192: return Nr192;
      KeyLen256: return Nr256;
      default:   return Nr128;
    endcase
  endfunction

  // State is column-major: byte (row r, column c) sits at bits 127-8*(4c+r).
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_mixcolumns.sv
// Combinational AES MixColumns over a full 128-bit column-major state.
module aes_mixcolumns
  import aes_pkg::*;
(
  input  logic [127:0] data_i,
  output logic [127:0] data_o
);

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] b0, b1, b2, b3;
    b0 = col[31:24];
    b1 = col[23:16];
    b2 = col[15:8];
    b3 = col[7:0];
    return {xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3,
            b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3,
            b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3,
            xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3)};
  endfunction

  always_comb begin
    data_o = '0;
    for (int c = 0; c < 4; c++) begin
      data_o[127-32*c -: 32] = mix_column(data_i[127-32*c -: 32]);
    end
  end

endmodule

// File: rtl/aes_encipher_core_p.sv
// AES encipher datapath with an external S-box (SBOX_LANES words per cycle) and
// external key schedule indexed by the round output.
module aes_encipher_core_p
  import aes_pkg::*;
#(
  parameter int unsigned SBOX_LANES = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      next,
  input  logic                      abort,
  input  logic [1:0]                keylen,
  output logic [3:0]                round,
  input  logic [127:0]              round_key,
  output logic [32*SBOX_LANES-1:0]  sboxw,
  input  logic [32*SBOX_LANES-1:0]  new_sboxw,
  input  logic [127:0]              block,
  output logic [127:0]              new_block,
  output logic                      ready,
  output logic                      done,
  output logic                      err
);

  if (SBOX_LANES != 1 && SBOX_LANES != 2 && SBOX_LANES != 4) begin : g_bad_lanes
    $error("SBOX_LANES must be 1, 2 or 4");
  end

  localparam int unsigned LaneW      = 32 * SBOX_LANES;
  localparam int unsigned SboxCycles = 4 / SBOX_LANES;
  localparam logic [1:0]  LastWord   = 2'(SboxCycles - 1);

  aes_state_e   state_q;
  logic [127:0] block_q;
  logic [3:0]   round_q;
  logic [1:0]   word_q;
  logic [1:0]   keylen_q;
  logic         ready_q, done_q, err_q;

  logic [127:0] sub_block, sr_block, mc_block, main_block;
  logic [3:0]   nr;

  assign nr = num_rounds(keylen_q);

  // Present the current word group to the S-box and splice the result back in.
  always_comb begin
    sboxw     = '0;
    sub_block = block_q;
    if (state_q == StSbox) begin
      for (int l = 0; l < SBOX_LANES; l++) begin
        sboxw[LaneW-1-32*l -: 32] =
            block_q[127-32*(int'(word_q)*SBOX_LANES+l) -: 32];
        sub_block[127-32*(int'(word_q)*SBOX_LANES+l) -: 32] =
            new_sboxw[LaneW-1-32*l -: 32];
      end
    end
  end

  assign sr_block = shift_rows(block_q);

  aes_mixcolumns u_mix (
    .data_i (sr_block),
    .data_o (mc_block)
  );

  // The final round skips MixColumns.
  assign main_block = ((round_q == nr) ? sr_block : mc_block) ^ round_key;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      block_q  <= '0;
      round_q  <= '0;
      word_q   <= '0;
      keylen_q <= 2'd0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (abort && state_q != StIdle) begin
        state_q <= StIdle;
        block_q <= '0;
        round_q <= '0;
        word_q  <= '0;
        ready_q <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (next && !abort) begin
              if (keylen == KeyLenRsvd) begin
                err_q <= 1'b1;
              end else begin
                keylen_q <= keylen;
                block_q  <= block;
                round_q  <= '0;
                ready_q  <= 1'b0;
                state_q  <= StInit;
              end
            end
          end
          StInit: begin
            block_q <= block_q ^ round_key;
            round_q <= 4'd1;
            word_q  <= '0;
            state_q <= StSbox;
          end
          StSbox: begin
            block_q <= sub_block;
            if (word_q == LastWord) begin
              word_q  <= '0;
              state_q <= StMain;
            end else begin
              word_q <= word_q + 2'd1;
            end
          end
          StMain: begin
            block_q <= main_block;
            if (round_q == nr) begin
              ready_q <= 1'b1;
              done_q  <= 1'b1;
              state_q <= StIdle;
            end else begin
              round_q <= round_q + 4'd1;
              state_q <= StSbox;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign round     = round_q;
  assign new_block = block_q;
  assign ready     = ready_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_aes_encipher_core_p.sv
// Bench: three cores (1, 2 and 4 S-box lanes) driven in lockstep against a
// byte-array AES reference with its own S-box and key schedule.
module tb_aes_encipher_core_p;

  logic         clk;
  logic         reset_n = 1'b0;
  logic         next_s;
  logic         abort_a [3];
  logic [1:0]   keylen_s;
  logic [127:0] block_s;
  logic [127:0] nb_a    [3];
  logic         ready_a [3];
  logic         done_a  [3];
  logic         err_a   [3];

  logic [7:0]   sbox_tab [256];
  logic [127:0] rk_tab   [16];
  logic [127:0] ref_st   [15];
  int           abort_k  [3] = '{22, 14, 10};

  int n_cmp = 0;
  int n_bad = 0;
  bit en_cmp = 1'b0;

  localparam logic [127:0] Pt   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] Ct1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] Ct2  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] Ct3  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] Key1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] Key2 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] Key3 =
      256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int inst, input logic [127:0] got,
                     input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s [inst %0d]: got %h, want %h", name, inst, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] v);
    return {sbox_tab[v[31:24]], sbox_tab[v[23:16]], sbox_tab[v[15:8]], sbox_tab[v[7:0]]};
  endfunction

  // S-box from first principles: multiplicative inverse then the affine map.
  task automatic build_sbox();
    logic [7:0]  inv;
    logic [15:0] d;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      d = {inv, inv};
      sbox_tab[x] = inv ^ d[14:7] ^ d[13:6] ^ d[12:5] ^ d[11:4] ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] tmp;
    logic [7:0]  rc;
    int          nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = subword({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = subword(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int r = 0; r < 16; r++)
      rk_tab[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  // Textbook cipher on a byte array; ref_st[r] is the state after round r.
  task automatic ref_run(input logic [127:0] pt, input int nr);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] x;
    x = pt ^ rk_tab[0];
    ref_st[0] = x;
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_tab[x[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int rw = 0; rw < 4; rw++) t[rw+4*c] = s[rw+4*((c+rw)%4)];
      for (int c = 0; c < 4; c++)
        for (int rw = 0; rw < 4; rw++)
          s[rw+4*c] = (r < nr) ? (gmul(8'h02, t[rw+4*c]) ^ gmul(8'h03, t[(rw+1)%4+4*c]) ^
                                  t[(rw+2)%4+4*c] ^ t[(rw+3)%4+4*c])
                               : t[rw+4*c];
      for (int i = 0; i < 16; i++) x[127-8*i -: 8] = s[i];
      x = x ^ rk_tab[r];
      ref_st[r] = x;
    end
  endtask

  task automatic prep(input logic [255:0] key, input int nk);
    expand(key, nk);
    ref_run(Pt, nk + 6);
    block_s = Pt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: plain; 1: stray next pulses; 2: keylen flipped mid-run; 3: abort in round 5.
  task automatic run(input logic [1:0] kl, input int mode, input logic [127:0] exp_ct);
    int lat [3];
    bit fin [3];
    int nr;
    nr = 10 + 2 * int'(kl);
    for (int g = 0; g < 3; g++) begin
      lat[g] = 0;
      fin[g] = 1'b0;
    end
    keylen_s = kl;
    next_s   = 1'b1;
    tick();
    next_s = 1'b0;
    // k counts edges with the accepting edge as 1.
    for (int k = 1; k <= 120; k++) begin
      for (int g = 0; g < 3; g++) begin
        if (done_a[g] && !fin[g]) begin
          fin[g] = 1'b1;
          lat[g] = k;
        end
        if (mode == 3 && k == abort_k[g] + 1) begin
          chk("abort_ready", g, 128'(ready_a[g]), 128'd1);
          chk("abort_block", g, nb_a[g], 128'd0);
          chk("abort_done", g, 128'(done_a[g]), 128'd0);
        end
      end
      if (mode == 1) next_s = (k >= 5 && k <= 7);
      if (mode == 2 && k == 3) keylen_s = 2'd0;
      if (mode == 3) for (int g = 0; g < 3; g++) abort_a[g] = (k == abort_k[g]);
      if (mode == 3 ? (k > abort_k[0]) : (fin[0] && fin[1] && fin[2])) break;
      tick();
    end
    next_s = 1'b0;
    for (int g = 0; g < 3; g++) abort_a[g] = 1'b0;
    if (mode != 3) begin
      for (int g = 0; g < 3; g++) begin
        chk("done_latency", g, 128'(lat[g]), 128'(2 + nr * (4 / (1 << g) + 1)));
        chk("ciphertext", g, nb_a[g], exp_ct);
      end
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    localparam int S = 4 / L;

    logic [3:0]      rnd;
    logic [127:0]    rkey;
    logic [32*L-1:0] sbw, nsbw;

    int           m_cnt, m_nr;
    bit           m_busy, m_ready, m_done, m_err;
    logic [127:0] m_nb;

    assign rkey = rk_tab[rnd];

    always_comb begin
      nsbw = '0;
      for (int l = 0; l < L; l++) nsbw[32*L-1-32*l -: 32] = subword(sbw[32*L-1-32*l -: 32]);
    end

    aes_encipher_core_p #(
      .SBOX_LANES (L)
    ) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .next      (next_s),
      .abort     (abort_a[g]),
      .keylen    (keylen_s),
      .round     (rnd),
      .round_key (rkey),
      .sboxw     (sbw),
      .new_sboxw (nsbw),
      .block     (block_s),
      .new_block (nb_a[g]),
      .ready     (ready_a[g]),
      .done      (done_a[g]),
      .err       (err_a[g])
    );

    // Words due at the S-box: untouched words of the previous round's state.
    function automatic logic [127:0] sbw_exp(input int cnt);
      int t, r, p;
      logic [127:0] v;
      t = cnt - 2;
      r = t / (S + 1) + 1;
      p = t % (S + 1);
      v = ref_st[r-1] << (32 * p * L);
      return v >> (128 - 32 * L);
    endfunction

    always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        m_busy  <= 1'b0;
        m_ready <= 1'b1;
        m_done  <= 1'b0;
        m_err   <= 1'b0;
        m_nb    <= '0;
        m_cnt   <= 0;
        m_nr    <= 10;
      end else begin
        m_done <= 1'b0;
        m_err  <= 1'b0;
        if (m_busy) begin
          if (abort_a[g]) begin
            m_busy  <= 1'b0;
            m_ready <= 1'b1;
            m_nb    <= '0;
          end else begin
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 == 2 + m_nr * (S + 1)) begin
              m_busy  <= 1'b0;
              m_ready <= 1'b1;
              m_done  <= 1'b1;
              m_nb    <= ref_st[m_nr];
            end
          end
        end else if (next_s && !abort_a[g]) begin
          if (keylen_s == 2'd3) begin
            m_err <= 1'b1;
          end else begin
            m_busy  <= 1'b1;
            m_ready <= 1'b0;
            m_cnt   <= 1;
            m_nr    <= 10 + 2 * int'(keylen_s);
          end
        end
      end
    end

    always @(negedge clk) begin
      if (en_cmp && reset_n) begin
        chk("ready", g, 128'(ready_a[g]), 128'(m_ready));
        chk("done", g, 128'(done_a[g]), 128'(m_done));
        chk("err", g, 128'(err_a[g]), 128'(m_err));
        if (!m_busy) chk("new_block", g, nb_a[g], m_nb);
        if (m_busy && m_cnt == 1) chk("round_init", g, 128'(rnd), 128'd0);
        if (m_busy && m_cnt >= 2 && ((m_cnt - 2) % (S + 1)) < S) begin
          chk("round", g, 128'(rnd), 128'((m_cnt - 2) / (S + 1) + 1));
          chk("sboxw", g, 128'(sbw), sbw_exp(m_cnt));
        end else begin
          chk("sboxw_zero", g, 128'(sbw), 128'd0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    next_s   = 1'b0;
    keylen_s = 2'd0;
    block_s  = '0;
    for (int g = 0; g < 3; g++) abort_a[g] = 1'b0;
    for (int r = 0; r < 16; r++) rk_tab[r] = '0;
    for (int r = 0; r < 15; r++) ref_st[r] = '0;
    build_sbox();

    chk("sbox_00", 0, 128'(sbox_tab[8'h00]), 128'h63);
    chk("sbox_01", 0, 128'(sbox_tab[8'h01]), 128'h7c);
    chk("sbox_53", 0, 128'(sbox_tab[8'h53]), 128'hed);
    chk("gmul_57_83", 0, 128'(gmul(8'h57, 8'h83)), 128'hc1);
    chk("gmul_57_13", 0, 128'(gmul(8'h57, 8'h13)), 128'hfe);

    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      chk("rst_ready", g, 128'(ready_a[g]), 128'd1);
      chk("rst_block", g, nb_a[g], 128'd0);
      chk("rst_done", g, 128'(done_a[g]), 128'd0);
      chk("rst_err", g, 128'(err_a[g]), 128'd0);
    end
    reset_n = 1'b1;
    en_cmp  = 1'b1;
    tick();

    // AES-128
    prep(Key1, 4);
    chk("ref_rk1", 0, rk_tab[1], 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    chk("ref_rk10", 0, rk_tab[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    chk("ref_ct1", 0, ref_st[10], Ct1);
    run(2'd0, 0, Ct1);
    tick();

    // AES-192 with stray next pulses mid-run
    prep(Key2, 6);
    chk("ref_ct2", 0, ref_st[12], Ct2);
    run(2'd1, 1, Ct2);
    tick();

    // AES-256 with keylen dropped to 0 mid-run
    prep(Key3, 8);
    chk("ref_ct3", 0, ref_st[14], Ct3);
    run(2'd2, 2, Ct3);
    tick();

    // Reserved key length: err pulse, nothing else moves
    keylen_s = 2'd3;
    next_s   = 1'b1;
    tick();
    next_s = 1'b0;
    for (int g = 0; g < 3; g++) begin
      chk("rsvd_err", g, 128'(err_a[g]), 128'd1);
      chk("rsvd_ready", g, 128'(ready_a[g]), 128'd1);
      chk("rsvd_block", g, nb_a[g], Ct3);
    end
    tick();
    for (int g = 0; g < 3; g++) chk("rsvd_err_clr", g, 128'(err_a[g]), 128'd0);

    // Abort in round 5 S-box phase, then immediate restart
    prep(Key1, 4);
    run(2'd0, 3, Ct1);
    run(2'd0, 0, Ct1);
    tick();

    // Asynchronous reset mid-run
    prep(Key2, 6);
    keylen_s = 2'd1;
    next_s   = 1'b1;
    tick();
    next_s = 1'b0;
    repeat (15) tick();
    #2;
    reset_n = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) begin
      chk("mid_rst_ready", g, 128'(ready_a[g]), 128'd1);
      chk("mid_rst_block", g, nb_a[g], 128'd0);
      chk("mid_rst_done", g, 128'(done_a[g]), 128'd0);
    end
    tick();
    reset_n = 1'b1;
    tick();

    prep(Key1, 4);
    run(2'd0, 0, Ct1);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
